// File: rtl/next_pc_pkg.sv
// Shared widths, increment and reset address for the next-PC selector.
// Also provides the pc_t program-counter type.
package next_pc_pkg;
  localparam int PC_W    = 64;
  localparam int PC_INCR = 4;

  typedef logic [PC_W-1:0] pc_t;

  localparam pc_t RESET_PC_DEFAULT = '0;
endpackage

// File: rtl/next_pc_adder.sv
// Plain W-bit modulo adder; the carry-out is dropped on purpose.
// Negative offsets therefore work through two's-complement wrap.
module next_pc_adder
  import next_pc_pkg::*;
#(
  parameter int W = PC_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/next_pc_logic.sv
// Next-PC select (PC+4 or branch target) with a registered PCReg copy.
// Branch statistics counters are added when NEXT_PC_BRANCH_STATS_EN is defined.
module next_pc_logic
  import next_pc_pkg::*;
#(
  parameter int              PC_W     = next_pc_pkg::PC_W,
  parameter int              PC_INCR  = next_pc_pkg::PC_INCR,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic [PC_W-1:0] CurrentPC,
  input  logic [PC_W-1:0] SignExtImm64,
  input  logic            Branch,
  input  logic            ALUZero,
  input  logic            Uncondbranch,
  output logic [PC_W-1:0] NextPC,
  output logic            BranchTaken,
  output logic [PC_W-1:0] PCReg
`ifdef NEXT_PC_BRANCH_STATS_EN
  ,
  output logic [31:0]     SeqCount,
  output logic [31:0]     CondTakenCount,
  output logic [31:0]     UncondCount
`endif
);

  localparam logic [PC_W-1:0] INCR_C = PC_W'(PC_INCR);

  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] target_pc;
  logic [PC_W-1:0] pc_reg_d;
  logic [PC_W-1:0] pc_reg_q;

  next_pc_adder #(.W(PC_W)) u_seq_adder (
    .a   (CurrentPC),
    .b   (INCR_C),
    .sum (seq_pc)
  );

  next_pc_adder #(.W(PC_W)) u_target_adder (
    .a   (CurrentPC),
    .b   (SignExtImm64),
    .sum (target_pc)
  );

  // Plain operators so an X on a control bit reaches the outputs unmasked.
  assign BranchTaken = Uncondbranch | (Branch & ALUZero);
  assign NextPC      = BranchTaken ? target_pc : seq_pc;

  always_comb begin
    pc_reg_d = NextPC;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) pc_reg_q <= RESET_PC;
    else       pc_reg_q <= pc_reg_d;
  end

  assign PCReg = pc_reg_q;

`ifdef NEXT_PC_BRANCH_STATS_EN
  logic [31:0] seq_count_d,  seq_count_q;
  logic [31:0] cond_count_d, cond_count_q;
  logic [31:0] unc_count_d,  unc_count_q;

  // Exactly one counter advances per edge; unconditional wins over conditional.
  always_comb begin
    seq_count_d  = seq_count_q;
    cond_count_d = cond_count_q;
    unc_count_d  = unc_count_q;
    if (Uncondbranch)          unc_count_d  = unc_count_q + 32'd1;
    else if (Branch & ALUZero) cond_count_d = cond_count_q + 32'd1;
    else                       seq_count_d  = seq_count_q + 32'd1;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      seq_count_q  <= '0;
      cond_count_q <= '0;
      unc_count_q  <= '0;
    end else begin
      seq_count_q  <= seq_count_d;
      cond_count_q <= cond_count_d;
      unc_count_q  <= unc_count_d;
    end
  end

  assign SeqCount       = seq_count_q;
  assign CondTakenCount = cond_count_q;
  assign UncondCount    = unc_count_q;
`endif

endmodule

// File: tb/tb_next_pc_logic.sv
// Directed bench for next_pc_logic: combinational vector table plus PCReg/reset sequences.
// Counter checks are compiled in when NEXT_PC_BRANCH_STATS_EN is defined.
module tb_next_pc_logic;

  logic        CLK;
  logic        Reset;
  logic [63:0] CurrentPC;
  logic [63:0] SignExtImm64;
  logic        Branch;
  logic        ALUZero;
  logic        Uncondbranch;
  logic [63:0] NextPC;
  logic        BranchTaken;
  logic [63:0] PCReg;
`ifdef NEXT_PC_BRANCH_STATS_EN
  logic [31:0] SeqCount;
  logic [31:0] CondTakenCount;
  logic [31:0] UncondCount;
`endif

  int checks = 0;
  int errors = 0;

  next_pc_logic dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .CurrentPC    (CurrentPC),
    .SignExtImm64 (SignExtImm64),
    .Branch       (Branch),
    .ALUZero      (ALUZero),
    .Uncondbranch (Uncondbranch),
    .NextPC       (NextPC),
    .BranchTaken  (BranchTaken),
    .PCReg        (PCReg)
`ifdef NEXT_PC_BRANCH_STATS_EN
    ,
    .SeqCount       (SeqCount),
    .CondTakenCount (CondTakenCount),
    .UncondCount    (UncondCount)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [63:0] cur;
    logic [63:0] imm;
    logic        br;
    logic        zero;
    logic        unc;
    logic [63:0] exp_next;
    logic        exp_taken;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [63:0] cur, input logic [63:0] imm,
                                input logic br, input logic zero, input logic unc);
    CurrentPC    = cur;
    SignExtImm64 = imm;
    Branch       = br;
    ALUZero      = zero;
    Uncondbranch = unc;
  endtask

`ifdef NEXT_PC_BRANCH_STATS_EN
  task automatic check_counts(input string name, input int s, input int c, input int u);
    check({name, " SeqCount"},       64'(SeqCount),       64'(s));
    check({name, " CondTakenCount"}, 64'(CondTakenCount), 64'(c));
    check({name, " UncondCount"},    64'(UncondCount),    64'(u));
  endtask
`endif

  initial begin
    vecs[0] = '{"seq",            64'd10,  64'd0,  1'b0, 1'b0, 1'b0, 64'd14, 1'b0};
    vecs[1] = '{"uncond",         64'd10,  64'd8,  1'b0, 1'b0, 1'b1, 64'd18, 1'b1};
    vecs[2] = '{"cbz taken",      64'd10,  64'd12, 1'b1, 1'b1, 1'b0, 64'd22, 1'b1};
    vecs[3] = '{"cbz not taken",  64'd10,  64'd12, 1'b1, 1'b0, 1'b0, 64'd14, 1'b0};
    vecs[4] = '{"pc wrap",        64'hFFFF_FFFF_FFFF_FFFC, 64'd40, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0};
    vecs[5] = '{"neg imm",        64'd100, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0, 1'b1, 64'd92, 1'b1};
    vecs[6] = '{"zero ignored",   64'd200, 64'd64, 1'b0, 1'b1, 1'b0, 64'd204, 1'b0};
    vecs[7] = '{"both branch",    64'd200, 64'd64, 1'b1, 1'b1, 1'b1, 64'd264, 1'b1};
    vecs[8] = '{"uncond no zero", 64'h1000, 64'h20, 1'b1, 1'b0, 1'b1, 64'h1020, 1'b1};
    vecs[9] = '{"target wrap",    64'hFFFF_FFFF_FFFF_FFF0, 64'h30, 1'b1, 1'b1, 1'b0, 64'h20, 1'b1};

    Reset = 1'b1;
    apply_stimulus(64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    #2;
    check("PCReg in reset", PCReg, 64'd0);

    // Combinational outputs must be valid while Reset is still high.
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      apply_stimulus(vecs[i].cur, vecs[i].imm, vecs[i].br, vecs[i].zero, vecs[i].unc);
      #1;
      check({vecs[i].name, " NextPC"}, NextPC, vecs[i].exp_next);
      check({vecs[i].name, " BranchTaken"}, 64'(BranchTaken), 64'(vecs[i].exp_taken));
    end
    check("PCReg held by reset", PCReg, 64'd0);
`ifdef NEXT_PC_BRANCH_STATS_EN
    check_counts("reset", 0, 0, 0);
`endif

    @(negedge CLK);
    apply_stimulus(64'd10, 64'd0, 1'b0, 1'b0, 1'b0);
    Reset = 1'b0;
    #1;
    check("PCReg after release mid-cycle", PCReg, 64'd0);
    @(posedge CLK); #1;
    check("PCReg first edge", PCReg, 64'd14);
`ifdef NEXT_PC_BRANCH_STATS_EN
    check_counts("first edge", 1, 0, 0);
`endif

    @(negedge CLK);
    apply_stimulus(64'd14, 64'd8, 1'b0, 1'b0, 1'b1);
    @(posedge CLK); #1;
    check("PCReg uncond edge", PCReg, 64'd22);
`ifdef NEXT_PC_BRANCH_STATS_EN
    check_counts("uncond edge", 1, 0, 1);
`endif

    @(negedge CLK);
    apply_stimulus(64'd22, 64'd16, 1'b1, 1'b1, 1'b0);
    @(posedge CLK); #1;
    check("PCReg cbz edge", PCReg, 64'd38);
`ifdef NEXT_PC_BRANCH_STATS_EN
    check_counts("cbz edge", 1, 1, 1);
`endif

    @(negedge CLK);
    apply_stimulus(64'd38, 64'd16, 1'b1, 1'b1, 1'b1);
    @(posedge CLK); #1;
    check("PCReg both edge", PCReg, 64'd54);
`ifdef NEXT_PC_BRANCH_STATS_EN
    check_counts("both edge", 1, 1, 2);
`endif

    @(negedge CLK);
    apply_stimulus(64'd54, 64'd16, 1'b1, 1'b0, 1'b0);
    @(posedge CLK); #1;
    check("PCReg cbz fallthrough edge", PCReg, 64'd58);
`ifdef NEXT_PC_BRANCH_STATS_EN
    check_counts("fallthrough edge", 2, 1, 2);
`endif

    // Asynchronous reset asserted between edges must clear immediately.
    @(negedge CLK);
    #2;
    Reset = 1'b1;
    #1;
    check("PCReg async reset", PCReg, 64'd0);
`ifdef NEXT_PC_BRANCH_STATS_EN
    check_counts("async reset", 0, 0, 0);
`endif
    @(posedge CLK); #1;
    check("PCReg reset held over edge", PCReg, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
